// File: rtl/opcode_encoder.sv
// opcode_encoder: one-hot ALU op request -> 4-bit select code, queued in a FIFO.
// Build option OPENC_STRICT_EN: drop malformed requests instead of queuing CLEAR.
module opcode_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [11:0]      req_onehot,
    output logic             req_ready,
    output logic             out_valid,
    output logic [3:0]       out_sel,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic          well;
    logic [3:0]    enc;
    logic          push;
    logic          pop;
    logic          enq;
    logic          full;
    logic          empty;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    assign req_ready = !full;
    assign out_valid = !empty;
    assign out_sel   = empty ? 4'hF : mem[rptr];

    assign push = req_valid && req_ready;
    assign pop  = out_valid && out_ready;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign well = (req_onehot != '0) &&
                  ((req_onehot & (req_onehot - 12'd1)) == '0);

`ifdef OPENC_STRICT_EN
    assign enq = push && well;
`else
    assign enq = push;
`endif

    // Encode the one-hot request; anything malformed becomes CLEAR.
    always_comb begin
        enc = 4'hF;
        if (well) begin
            unique case (1'b1)
                req_onehot[0]:  enc = 4'b0000;
                req_onehot[1]:  enc = 4'b0001;
                req_onehot[2]:  enc = 4'b0010;
                req_onehot[3]:  enc = 4'b0011;
                req_onehot[4]:  enc = 4'b0100;
                req_onehot[5]:  enc = 4'b0101;
                req_onehot[6]:  enc = 4'b0110;
                req_onehot[7]:  enc = 4'b1000;
                req_onehot[8]:  enc = 4'b1001;
                req_onehot[9]:  enc = 4'b1010;
                req_onehot[10]: enc = 4'b1011;
                req_onehot[11]: enc = 4'b1111;
                default:        enc = 4'hF;
            endcase
        end
    end

    // Storage is left uninitialised; only pointers and count gate its use.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem[wptr] <= enc;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Malformed-request pulse and saturating debug counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= push && !well;
            if (push && !well && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opcode_encoder.sv
// Self-checking bench for opcode_encoder: directed vectors, scoreboard queue,
// independent output monitor.
module tb_opcode_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [11:0] req_onehot = '0;
    logic        req_ready;
    logic        out_valid;
    logic [3:0]  out_sel;
    logic        out_ready = 1'b0;
    logic        err;
    logic [7:0]  err_count;

    int n_chk = 0;
    int n_fail = 0;
    int err_seen = 0;
    logic [3:0] sbq[$];

`ifdef OPENC_STRICT_EN
    localparam bit BAD_ENQ = 1'b0;
`else
    localparam bit BAD_ENQ = 1'b1;
`endif

    opcode_encoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_onehot(req_onehot),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_sel(out_sel),
        .out_ready(out_ready),
        .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compare every issued select code against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_seen++;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 32'(out_sel), 32'hDEAD);
                end else begin
                    chk("out_sel_order", 32'(out_sel), 32'(sbq.pop_front()));
                end
            end else if (!out_valid) begin
                chk("idle_sel", 32'(out_sel), 32'hF);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the push edge; bounded wait.
    task automatic push_req(input logic [11:0] oh, input logic [3:0] exp, input bit enq);
        int tries;
        req_valid  = 1'b1;
        req_onehot = oh;
        tries = 0;
        while (!req_ready && tries < 50) begin
            cycle();
            tries++;
        end
        if (!req_ready) begin
            chk("push_timeout", 32'(req_ready), 32'h1);
        end else begin
            @(posedge clk);
            if (enq) sbq.push_back(exp);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while (out_valid && t < 40) begin
            cycle();
            t++;
        end
        chk("drain_empty", 32'(out_valid), 32'h0);
    endtask

    logic [11:0] oh_tab [12];
    logic [3:0]  sel_tab [12];

    initial begin
        int n;
        for (int i = 0; i < 12; i++) oh_tab[i] = 12'(1) << i;
        sel_tab[0] = 4'h0; sel_tab[1] = 4'h1; sel_tab[2]  = 4'h2; sel_tab[3]  = 4'h3;
        sel_tab[4] = 4'h4; sel_tab[5] = 4'h5; sel_tab[6]  = 4'h6; sel_tab[7]  = 4'h8;
        sel_tab[8] = 4'h9; sel_tab[9] = 4'hA; sel_tab[10] = 4'hB; sel_tab[11] = 4'hF;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'hF);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        rst = 1'b0;
        cycle();

        // All twelve encodings, streamed with one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_req(oh_tab[i], sel_tab[i], 1'b1);
            chk("latency_valid", 32'(out_valid), 32'h1);
            chk("latency_sel", 32'(out_sel), 32'(sel_tab[i]));
        end
        drain();
        chk("no_err_wellformed", 32'(err_seen), 32'h0);

        // Fill to full, hold the fifth request, single pop frees a slot
        out_ready = 1'b0;
        for (int i = 7; i < 11; i++) push_req(oh_tab[i], sel_tab[i], 1'b1);
        req_valid  = 1'b1;
        req_onehot = oh_tab[3];
        chk("full_ready_low", 32'(req_ready), 32'h0);
        repeat (3) cycle();
        chk("full_hold_ready", 32'(req_ready), 32'h0);
        chk("full_hold_valid", 32'(out_valid), 32'h1);
        chk("full_head", 32'(out_sel), 32'h8);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("ready_after_pop", 32'(req_ready), 32'h1);
        @(posedge clk);
        sbq.push_back(4'h3);
        #1;
        req_valid = 1'b0;
        chk("full_again", 32'(req_ready), 32'h0);
        drain();

        // Steady state at count 2: push and pop every cycle across wrap
        out_ready = 1'b0;
        push_req(oh_tab[0], sel_tab[0], 1'b1);
        push_req(oh_tab[1], sel_tab[1], 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_req(oh_tab[(i + 2) % 12], sel_tab[(i + 2) % 12], 1'b1);
            chk("stream_ready", 32'(req_ready), 32'h1);
        end
        n = 0;
        for (int t = 0; t < 10; t++) begin
            if (out_valid) n++;
            cycle();
        end
        chk("stream_count2", 32'(n), 32'h2);

        // Malformed requests
        out_ready = 1'b1;
        push_req(12'h000, 4'hF, BAD_ENQ);
        chk("bad0_err", 32'(err), 32'h1);
        chk("bad0_cnt", 32'(err_count), 32'h1);
        if (!BAD_ENQ) chk("bad0_strict_empty", 32'(out_valid), 32'h0);
        else chk("bad0_clear", 32'(out_sel), 32'hF);
        cycle();
        chk("bad0_err_pulse", 32'(err), 32'h0);
        push_req(12'h003, 4'hF, BAD_ENQ);
        chk("bad1_err", 32'(err), 32'h1);
        chk("bad1_cnt", 32'(err_count), 32'h2);
        if (!BAD_ENQ) chk("bad1_strict_empty", 32'(out_valid), 32'h0);
        else chk("bad1_valid", 32'(out_valid), 32'h1);
        cycle();
        chk("bad1_err_pulse", 32'(err), 32'h0);
        chk("bad_err_seen", 32'(err_seen), 32'h2);
        drain();

        // Saturation of err_count
        for (int i = 0; i < 300; i++) begin
            push_req(12'hFFF, 4'hF, BAD_ENQ);
            if (i == 99) chk("errcnt_mid", 32'(err_count), 32'd102);
        end
        chk("errcnt_sat", 32'(err_count), 32'd255);
        cycle();
        chk("errcnt_hold", 32'(err_count), 32'd255);
        drain();

        // Reset with entries queued and a push pending
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_req(oh_tab[i + 4], sel_tab[i + 4], 1'b1);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        req_valid  = 1'b1;
        req_onehot = oh_tab[2];
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = 1'b0;
        sbq.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_sel", 32'(out_sel), 32'hF);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_errcnt", 32'(err_count), 32'h0);
        cycle();
        chk("rst_push_dropped", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        push_req(oh_tab[9], sel_tab[9], 1'b1);
        chk("post_rst_sel", 32'(out_sel), 32'hA);
        drain();
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/opcode_encoder.md
# opcode_encoder

Encoder and issue queue for the ALU's 4-bit operation select; the opposite direction of the select-to-one-hot opcode decoder. Control logic presents one operation as a 12-bit one-hot request. This block validates it, encodes it to the 4-bit select code, buffers it in a small FIFO, and issues select codes to the ALU datapath under a valid/ready handshake. It also counts malformed requests for debug.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CNT_W, 8, width of err_count
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_onehot  input  12  one-hot operation request
- req_ready  output  1  block can accept a request
- out_valid  output  1  select code available
- out_sel  output  4  encoded select code (head of FIFO)
- out_ready  input  1  consumer takes out_sel this cycle
- err  output  1  one-cycle pulse: malformed request was accepted
- err_count  output  CNT_W  saturating count of malformed requests

## Operation
- One-hot bit to select code mapping:
  - bit0 AND → 0000, bit1 OR → 0001, bit2 NOT → 0010, bit3 XOR → 0011
  - bit4 NAND → 0100, bit5 NOR → 0101, bit6 XNOR → 0110
  - bit7 ADD → 1000, bit8 SUB → 1001, bit9 SHRIGHT → 1010, bit10 SHLEFT → 1011
  - bit11 CLEAR → 1111
- Malformed request: req_onehot is zero or has more than one bit set. Handling depends on OPENC_STRICT_EN (see Configuration).
- Push: req_valid && req_ready. Pop: out_valid && out_ready.
- req_ready = !full. Depends only on occupancy; a pop in the same cycle does not free a slot for a push when the FIFO is full.
- out_valid = !empty.
- out_sel = head entry when out_valid; forced to 1111 when empty.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Read and write pointers wrap modulo DEPTH. count is (log2(DEPTH)+1) bits and runs 0..DEPTH.
- err_count increments on each accepted malformed request and saturates at all-ones; no wrap.
- Reset values, in effect the cycle after rst is sampled high:
  - pointers = 0, count = 0
  - out_valid = 0, out_sel = 1111, req_ready = 1
  - err = 0, err_count = 0
  - FIFO storage is not cleared.
- Reset mid-operation discards all queued entries. Any push or pop in the reset cycle is ignored.

## Timing
- Latency: a request pushed at edge N is visible at out_sel with out_valid = 1 after edge N, when the FIFO was empty. No combinational path from req_* to out_*.
- err asserts for exactly one cycle, in the cycle after the offending push edge.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full: req_ready low in the cycle after the DEPTH-th push, and stays low until after the first pop edge.

## Configuration
- OPENC_STRICT_EN defined:
  - A malformed request is accepted (handshake completes) but not enqueued.
  - err pulses and err_count increments.
  - FIFO contents and count are unchanged by that push.
- OPENC_STRICT_EN undefined:
  - A malformed request is enqueued as CLEAR (1111).
  - err pulses and err_count increments.
- Well-formed requests behave identically in both builds.

## Test plan
- Reset, then push the 12 one-hot codes (bit0..bit11) in order, with out_ready = 1 → out_sel sequence 0000,0001,0010,0011,0100,0101,0110,1000,1001,1010,1011,1111, each appearing one cycle after its push; err never asserts.
- DEPTH = 4, out_ready = 0, push 5 back-to-back requests → req_ready drops after the 4th push; the 5th is held; count = 4. Raise out_ready for one cycle → head popped; req_ready high the following cycle.
- Hold FIFO at count = 2 and push + pop every cycle for 20 cycles → count stays 2; output order matches input order across pointer wrap.
- Push 12'h000, then 12'h003 → err pulses twice; err_count = 2.
  - Strict build: out_valid stays 0.
  - Non-strict build: two 1111 entries are issued.
- Force 300 malformed pushes with CNT_W = 8 → err_count holds at 255.
- Assert rst for one cycle with 3 entries queued and a push pending → next cycle out_valid = 0, out_sel = 1111, req_ready = 1, err_count = 0; the pending push is not stored.
